// File: rtl/toy_bus_itcm_arb.sv
// Two-port round-robin arbiter and per-port read-response sequencer for the single-port ITCM SRAM.
// Latency: a read accepted in cycle T drives mem_en at T, captures rd_data at T+1 and presents ack_vld at T+2; writes complete at T.
// Backpressure: a port's reads stall (req_rdy=0) only when its response FIFO plus in-flight read would overflow; writes never stall.
//
// Ports:
//   clk, rst_n              sole clock, asynchronous active-low reset
//   inN_req_*               ToyBusReq request channel from master N (N = 0, 1), vld/rdy handshake
//   inN_ack_*               ToyBusAck read-response channel to master N, vld/rdy handshake
//   out0_mem_*              single SRAM port (word-addressed, rd_data one cycle after a read strobe)
module toy_bus_itcm_arb #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int IDW       = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in0_req_vld,
    output logic              in0_req_rdy,
    input  logic [AW-1:0]     in0_req_addr,
    input  logic [DW/8-1:0]   in0_req_strb,
    input  logic [DW-1:0]     in0_req_data,
    input  logic              in0_req_opcode,
    input  logic [IDW-1:0]    in0_req_src_id,
    input  logic [IDW-1:0]    in0_req_tgt_id,
    output logic              in0_ack_vld,
    input  logic              in0_ack_rdy,
    output logic              in0_ack_opcode,
    output logic [DW-1:0]     in0_ack_data,
    output logic [IDW-1:0]    in0_ack_src_id,
    output logic [IDW-1:0]    in0_ack_tgt_id,

    input  logic              in1_req_vld,
    output logic              in1_req_rdy,
    input  logic [AW-1:0]     in1_req_addr,
    input  logic [DW/8-1:0]   in1_req_strb,
    input  logic [DW-1:0]     in1_req_data,
    input  logic              in1_req_opcode,
    input  logic [IDW-1:0]    in1_req_src_id,
    input  logic [IDW-1:0]    in1_req_tgt_id,
    output logic              in1_ack_vld,
    input  logic              in1_ack_rdy,
    output logic              in1_ack_opcode,
    output logic [DW-1:0]     in1_ack_data,
    output logic [IDW-1:0]    in1_ack_src_id,
    output logic [IDW-1:0]    in1_ack_tgt_id,

    output logic              out0_mem_en,
    output logic [AW-1:0]     out0_mem_addr,
    input  logic [DW-1:0]     out0_mem_rd_data,
    output logic [DW-1:0]     out0_mem_wr_data,
    output logic [DW/8-1:0]   out0_mem_wr_byte_en,
    output logic              out0_mem_wr_en
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]          req_vld;
    logic [1:0]          req_op;
    logic [1:0]          ack_rdy;
    logic [1:0]          ack_vld;
    logic [1:0]          elig;
    logic [1:0]          grant;
    logic [1:0]          infl;
    logic [1:0]          pop;
    logic [IDW-1:0]      req_src [2];
    logic [CW:0]         commit  [2];
    logic [DW-1:0]       ack_dat [2];
    logic [IDW-1:0]      ack_tgt [2];

    logic                sel;
    logic                rd_gnt;
    logic [AW-1:0]       sel_addr;

    logic                last_gnt_q, last_gnt_d;
    logic                infl_vld_q, infl_vld_d;
    logic                infl_port_q, infl_port_d;
    logic [IDW-1:0]      infl_src_q, infl_src_d;

    logic [CW-1:0]       cnt_q    [2];
    logic [CW-1:0]       cnt_d    [2];
    logic [CW-1:0]       wr_ptr_q [2];
    logic [CW-1:0]       wr_ptr_d [2];
    logic [CW-1:0]       rd_ptr_q [2];
    logic [CW-1:0]       rd_ptr_d [2];
    logic [DW-1:0]       dat_q    [2][RSP_DEPTH];
    logic [DW-1:0]       dat_d    [2][RSP_DEPTH];
    logic [IDW-1:0]      tgt_q    [2][RSP_DEPTH];
    logic [IDW-1:0]      tgt_d    [2][RSP_DEPTH];

    assign req_vld    = {in1_req_vld, in0_req_vld};
    assign req_op     = {in1_req_opcode, in0_req_opcode};
    assign ack_rdy    = {in1_ack_rdy, in0_ack_rdy};
    assign req_src[0] = in0_req_src_id;
    assign req_src[1] = in1_req_src_id;

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign infl[p]    = infl_vld_q && (infl_port_q == 1'(p));
        assign ack_vld[p] = (cnt_q[p] != '0);
        assign pop[p]     = ack_vld[p] & ack_rdy[p];
        // Slots committed next cycle: current entries, plus the read whose data lands
        // next edge, minus the entry leaving now. A pop this cycle frees room for a grant.
        assign commit[p]  = {1'b0, cnt_q[p]} + (CW+1)'(infl[p]) - (CW+1)'(pop[p]);
        assign elig[p]    = req_vld[p] & (req_op[p] | (commit[p] < (CW+1)'(RSP_DEPTH)));
        // Gate the head with vld so an empty FIFO presents zeros rather than stale data.
        assign ack_dat[p] = ack_vld[p] ? dat_q[p][rd_ptr_q[p][PW-1:0]] : '0;
        assign ack_tgt[p] = ack_vld[p] ? tgt_q[p][rd_ptr_q[p][PW-1:0]] : '0;
    end

    // Round robin: on a tie the port not granted last wins; last_gnt resets to 1 so in0 wins first.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_gnt_q ? 2'b01 : 2'b10;
        end
    end

    // With no grant the memory fields follow in0 and mem_en stays low.
    assign sel    = grant[1];
    assign rd_gnt = (|grant) & ~req_op[sel];

    assign in0_req_rdy = grant[0];
    assign in1_req_rdy = grant[1];

    assign sel_addr            = sel ? in1_req_addr : in0_req_addr;
    assign out0_mem_en         = |grant;
    assign out0_mem_wr_en      = req_op[sel];
    assign out0_mem_wr_data    = sel ? in1_req_data : in0_req_data;
    assign out0_mem_wr_byte_en = sel ? in1_req_strb : in0_req_strb;

    always_comb begin
        out0_mem_addr       = '0;
        out0_mem_addr[26:0] = sel_addr[28:2];
    end

    assign in0_ack_vld    = ack_vld[0];
    assign in0_ack_opcode = 1'b0;
    assign in0_ack_data   = ack_dat[0];
    assign in0_ack_src_id = '0;
    assign in0_ack_tgt_id = ack_tgt[0];
    assign in1_ack_vld    = ack_vld[1];
    assign in1_ack_opcode = 1'b0;
    assign in1_ack_data   = ack_dat[1];
    assign in1_ack_src_id = '0;
    assign in1_ack_tgt_id = ack_tgt[1];

    // Byte offset, address bits above the ITCM window and target ids carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{sel_addr[1:0], sel_addr[AW-1:29], in0_req_tgt_id, in1_req_tgt_id};

    always_comb begin
        last_gnt_d  = last_gnt_q;
        if (|grant) begin
            last_gnt_d = grant[1];
        end
        infl_vld_d  = rd_gnt;
        infl_port_d = sel;
        infl_src_d  = req_src[sel];

        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dat_d    = dat_q;
        tgt_d    = tgt_q;
        for (int p = 0; p < 2; p++) begin
            // The in-flight read's data is on rd_data now; push it into its port's FIFO.
            if (infl[p]) begin
                dat_d[p][wr_ptr_q[p][PW-1:0]] = out0_mem_rd_data;
                tgt_d[p][wr_ptr_q[p][PW-1:0]] = infl_src_q;
                wr_ptr_d[p] = wr_ptr_q[p] + CW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + CW'(1);
            end
            cnt_d[p] = cnt_q[p] + CW'(infl[p]) - CW'(pop[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            infl_vld_q  <= 1'b0;
            infl_port_q <= 1'b0;
            infl_src_q  <= '0;
            for (int p = 0; p < 2; p++) begin
                cnt_q[p]    <= '0;
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    dat_q[p][i] <= '0;
                    tgt_q[p][i] <= '0;
                end
            end
        end else begin
            last_gnt_q  <= last_gnt_d;
            infl_vld_q  <= infl_vld_d;
            infl_port_q <= infl_port_d;
            infl_src_q  <= infl_src_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dat_q       <= dat_d;
            tgt_q       <= tgt_d;
        end
    end

endmodule

// File: tb/tb_toy_bus_itcm_arb.sv
// Directed bench for toy_bus_itcm_arb: cycle table plus hand-written multi-cycle sequences.
// Latency: inputs applied 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: ack_rdy driven per step to exercise FIFO fill, simultaneous pop and drain.
module tb_toy_bus_itcm_arb;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int IDW       = 4;
    localparam int RSP_DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in0_req_vld, in0_req_rdy, in0_req_opcode;
    logic [AW-1:0]   in0_req_addr;
    logic [3:0]      in0_req_strb;
    logic [DW-1:0]   in0_req_data;
    logic [IDW-1:0]  in0_req_src_id, in0_req_tgt_id;
    logic            in0_ack_vld, in0_ack_rdy, in0_ack_opcode;
    logic [DW-1:0]   in0_ack_data;
    logic [IDW-1:0]  in0_ack_src_id, in0_ack_tgt_id;
    logic            in1_req_vld, in1_req_rdy, in1_req_opcode;
    logic [AW-1:0]   in1_req_addr;
    logic [3:0]      in1_req_strb;
    logic [DW-1:0]   in1_req_data;
    logic [IDW-1:0]  in1_req_src_id, in1_req_tgt_id;
    logic            in1_ack_vld, in1_ack_rdy, in1_ack_opcode;
    logic [DW-1:0]   in1_ack_data;
    logic [IDW-1:0]  in1_ack_src_id, in1_ack_tgt_id;
    logic            out0_mem_en, out0_mem_wr_en;
    logic [AW-1:0]   out0_mem_addr;
    logic [DW-1:0]   out0_mem_rd_data = '0;
    logic [DW-1:0]   out0_mem_wr_data;
    logic [3:0]      out0_mem_wr_byte_en;

    int n_tests = 0;
    int n_fail  = 0;
    logic ovf_seen = 1'b0;

    always #5 clk = ~clk;

    toy_bus_itcm_arb #(.DW(DW), .AW(AW), .IDW(IDW), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy), .in0_req_addr(in0_req_addr),
        .in0_req_strb(in0_req_strb), .in0_req_data(in0_req_data), .in0_req_opcode(in0_req_opcode),
        .in0_req_src_id(in0_req_src_id), .in0_req_tgt_id(in0_req_tgt_id),
        .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy), .in0_ack_opcode(in0_ack_opcode),
        .in0_ack_data(in0_ack_data), .in0_ack_src_id(in0_ack_src_id), .in0_ack_tgt_id(in0_ack_tgt_id),
        .in1_req_vld(in1_req_vld), .in1_req_rdy(in1_req_rdy), .in1_req_addr(in1_req_addr),
        .in1_req_strb(in1_req_strb), .in1_req_data(in1_req_data), .in1_req_opcode(in1_req_opcode),
        .in1_req_src_id(in1_req_src_id), .in1_req_tgt_id(in1_req_tgt_id),
        .in1_ack_vld(in1_ack_vld), .in1_ack_rdy(in1_ack_rdy), .in1_ack_opcode(in1_ack_opcode),
        .in1_ack_data(in1_ack_data), .in1_ack_src_id(in1_ack_src_id), .in1_ack_tgt_id(in1_ack_tgt_id),
        .out0_mem_en(out0_mem_en), .out0_mem_addr(out0_mem_addr), .out0_mem_rd_data(out0_mem_rd_data),
        .out0_mem_wr_data(out0_mem_wr_data), .out0_mem_wr_byte_en(out0_mem_wr_byte_en),
        .out0_mem_wr_en(out0_mem_wr_en)
    );

    // SRAM model: 256 words, read data one cycle after the strobe, byte-enabled writes.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        if (out0_mem_en) begin
            if (out0_mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (out0_mem_wr_byte_en[b]) mem[out0_mem_addr[7:0]][8*b +: 8] <= out0_mem_wr_data[8*b +: 8];
            end else begin
                out0_mem_rd_data <= mem[out0_mem_addr[7:0]];
            end
        end
    end

    // Occupancy must never exceed the FIFO depth.
    always @(negedge clk) begin
        if (rst_n && ((dut.cnt_q[0] > 2'(RSP_DEPTH)) || (dut.cnt_q[1] > 2'(RSP_DEPTH)))) ovf_seen <= 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic op, input logic [31:0] a, input logic [3:0] s);
        in0_req_vld = v; in0_req_opcode = op; in0_req_addr = a; in0_req_src_id = s;
    endtask

    task automatic drv1(input logic v, input logic op, input logic [31:0] a, input logic [3:0] s);
        in1_req_vld = v; in1_req_opcode = op; in1_req_addr = a; in1_req_src_id = s;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, 32'h10, 4'd3);
        drv1(1'b0, 1'b0, 32'h40, 4'd5);
        in0_req_strb = 4'hF; in0_req_data = '0; in0_req_tgt_id = '0;
        in1_req_strb = 4'hF; in1_req_data = '0; in1_req_tgt_id = '0;
        in0_ack_rdy = 1'b1; in1_ack_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic v0, o0, v1, o1, ar0, ar1;
        logic r0, r1, en, we, av0, av1;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Contention from reset (rows 1-5), drain, then in1 stalled while in0 streams (rows 9-15).
        //           v0 o0 v1 o1 ar0 ar1 | r0 r1 en we av0 av1 | mem_addr
        tbl[0]  = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 32'h04};
        tbl[1]  = '{1, 0, 1, 0, 1, 1,   1, 0, 1, 0, 0, 0, 32'h04};
        tbl[2]  = '{1, 0, 1, 0, 1, 1,   0, 1, 1, 0, 0, 0, 32'h10};
        tbl[3]  = '{1, 0, 1, 0, 1, 1,   1, 0, 1, 0, 1, 0, 32'h04};
        tbl[4]  = '{1, 0, 1, 0, 1, 1,   0, 1, 1, 0, 0, 1, 32'h10};
        tbl[5]  = '{1, 0, 1, 0, 1, 1,   1, 0, 1, 0, 1, 0, 32'h04};
        tbl[6]  = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1, 32'h04};
        tbl[7]  = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 32'h04};
        tbl[8]  = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 32'h04};
        tbl[9]  = '{1, 0, 1, 0, 1, 0,   0, 1, 1, 0, 0, 0, 32'h10};
        tbl[10] = '{1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 0, 0, 32'h04};
        tbl[11] = '{1, 0, 1, 0, 1, 0,   0, 1, 1, 0, 0, 1, 32'h10};
        tbl[12] = '{1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 1, 1, 32'h04};
        tbl[13] = '{1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 0, 1, 32'h04};
        tbl[14] = '{1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 1, 1, 32'h04};
        tbl[15] = '{1, 0, 1, 0, 1, 0,   1, 0, 1, 0, 1, 1, 32'h04};
        tbl[16] = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 1, 32'h04};
        tbl[17] = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 1, 32'h04};
        tbl[18] = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 32'h04};

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst.ack_vld0", in0_ack_vld, 0);
        chk("rst.ack_vld1", in1_ack_vld, 0);
        chk("rst.ack_data0", in0_ack_data, 0);
        chk("rst.ack_data1", in1_ack_data, 0);
        chk("rst.ack_tgt0", in0_ack_tgt_id, 0);
        chk("rst.ack_tgt1", in1_ack_tgt_id, 0);
        chk("rst.mem_en", out0_mem_en, 0);
        chk("rst.req_rdy0", in0_req_rdy, 0);

        // ---- single read ----
        step(); drv0(1, 0, 32'h10, 4'd3); #1;
        chk("rd.rdy0", in0_req_rdy, 1);
        chk("rd.mem_en", out0_mem_en, 1);
        chk("rd.wr_en", out0_mem_wr_en, 0);
        chk("rd.mem_addr", out0_mem_addr, 32'h4);
        step(); drv0(0, 0, 32'h10, 4'd3); #1;
        chk("rd.t1_ack_vld", in0_ack_vld, 0);
        step(); #1;
        chk("rd.t2_ack_vld", in0_ack_vld, 1);
        chk("rd.t2_ack_data", in0_ack_data, 32'hDEAD_BEEF);
        chk("rd.t2_ack_tgt", in0_ack_tgt_id, 3);
        chk("rd.t2_ack_opc", in0_ack_opcode, 0);
        chk("rd.t2_ack_src", in0_ack_src_id, 0);
        step(); #1;
        chk("rd.t3_ack_vld", in0_ack_vld, 0);

        // ---- cycle table ----
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step();
            drv0(tbl[i].v0, tbl[i].o0, 32'h10, 4'd3);
            drv1(tbl[i].v1, tbl[i].o1, 32'h40, 4'd5);
            in0_ack_rdy = tbl[i].ar0;
            in1_ack_rdy = tbl[i].ar1;
            #1;
            chk($sformatf("vec%0d.rdy0", i), in0_req_rdy, tbl[i].r0);
            chk($sformatf("vec%0d.rdy1", i), in1_req_rdy, tbl[i].r1);
            chk($sformatf("vec%0d.mem_en", i), out0_mem_en, tbl[i].en);
            chk($sformatf("vec%0d.wr_en", i), out0_mem_wr_en, tbl[i].we);
            chk($sformatf("vec%0d.ack_vld0", i), in0_ack_vld, tbl[i].av0);
            chk($sformatf("vec%0d.ack_vld1", i), in1_ack_vld, tbl[i].av1);
            chk($sformatf("vec%0d.mem_addr", i), out0_mem_addr, tbl[i].addr);
        end

        // ---- in1 backpressure, full FIFO with simultaneous pop, in-order drain ----
        do_reset();
        step(); in1_ack_rdy = 0; drv1(1, 0, 32'h40, 4'd5); #1;
        chk("bp.s1_rdy1", in1_req_rdy, 1);
        step(); drv1(1, 0, 32'h44, 4'd6); #1;
        chk("bp.s2_rdy1", in1_req_rdy, 1);
        step(); drv1(1, 0, 32'h48, 4'd7); #1;
        chk("bp.s3_rdy1", in1_req_rdy, 0);
        chk("bp.s3_ack_vld", in1_ack_vld, 1);
        chk("bp.s3_ack_data", in1_ack_data, 32'h1000_0010);
        step(); #1;
        chk("bp.s4_rdy1", in1_req_rdy, 0);
        chk("bp.s4_hold_data", in1_ack_data, 32'h1000_0010);
        chk("bp.s4_hold_tgt", in1_ack_tgt_id, 5);
        step(); in1_ack_rdy = 1; #1;
        chk("bp.s5_pop_grant", in1_req_rdy, 1);
        chk("bp.s5_mem_addr", out0_mem_addr, 32'h12);
        chk("bp.s5_ack_data", in1_ack_data, 32'h1000_0010);
        step(); in1_ack_rdy = 0; drv1(1, 0, 32'h4C, 4'd8); #1;
        chk("bp.s6_rdy1", in1_req_rdy, 0);
        chk("bp.s6_ack_data", in1_ack_data, 32'h1000_0011);
        chk("bp.s6_ack_tgt", in1_ack_tgt_id, 6);
        step(); in1_ack_rdy = 1; drv1(0, 0, 32'h40, 4'd5); #1;
        chk("bp.s7_ack_data", in1_ack_data, 32'h1000_0011);
        step(); #1;
        chk("bp.s8_ack_vld", in1_ack_vld, 1);
        chk("bp.s8_ack_data", in1_ack_data, 32'h1000_0012);
        chk("bp.s8_ack_tgt", in1_ack_tgt_id, 7);
        step(); #1;
        chk("bp.s9_ack_vld", in1_ack_vld, 0);

        // ---- write while in0 FIFO is full ----
        do_reset();
        step(); in0_ack_rdy = 0; drv0(1, 0, 32'h10, 4'd3); #1;
        chk("wr.c1_rdy0", in0_req_rdy, 1);
        step(); drv0(1, 0, 32'h14, 4'd4); #1;
        chk("wr.c2_rdy0", in0_req_rdy, 1);
        step(); drv0(1, 0, 32'h18, 4'd9); #1;
        chk("wr.c3_rdy0", in0_req_rdy, 0);
        step(); drv0(1, 1, 32'h20, 4'd2); in0_req_data = 32'h1234_5678; in0_req_strb = 4'hF; #1;
        chk("wr.c4_rdy0", in0_req_rdy, 1);
        chk("wr.c4_mem_en", out0_mem_en, 1);
        chk("wr.c4_wr_en", out0_mem_wr_en, 1);
        chk("wr.c4_mem_addr", out0_mem_addr, 32'h8);
        chk("wr.c4_wr_data", out0_mem_wr_data, 32'h1234_5678);
        chk("wr.c4_byte_en", out0_mem_wr_byte_en, 4'hF);
        step(); drv0(0, 0, 32'h10, 4'd3); in0_ack_rdy = 1; #1;
        chk("wr.c5_ack_data", in0_ack_data, 32'hDEAD_BEEF);
        step(); #1;
        chk("wr.c6_ack_data", in0_ack_data, 32'h1000_0005);
        chk("wr.c6_ack_tgt", in0_ack_tgt_id, 4);
        step(); #1;
        chk("wr.c7_no_ack", in0_ack_vld, 0);
        step(); drv0(1, 0, 32'h20, 4'd1); #1;
        chk("wr.c8_rdy0", in0_req_rdy, 1);
        step(); drv0(0, 0, 32'h10, 4'd3); #1;
        step(); #1;
        chk("wr.readback", in0_ack_data, 32'h1234_5678);

        // ---- reset the cycle after a read grant ----
        do_reset();
        step(); drv0(1, 0, 32'h10, 4'd3); #1;
        chk("mr.grant0", in0_req_rdy, 1);
        step(); drv0(0, 0, 32'h10, 4'd3); rst_n = 1'b0; #1;
        chk("mr.in_reset_ack", in0_ack_vld, 0);
        step(); rst_n = 1'b1; #1;
        chk("mr.rel_ack0", in0_ack_vld, 0);
        step(); #1;
        chk("mr.rel1_ack0", in0_ack_vld, 0);
        step(); #1;
        chk("mr.rel2_ack0", in0_ack_vld, 0);
        step(); drv0(1, 0, 32'h10, 4'd3); drv1(1, 0, 32'h40, 4'd5); #1;
        chk("mr.tie_rdy0", in0_req_rdy, 1);
        chk("mr.tie_rdy1", in1_req_rdy, 0);
        step(); idle(); #1;
        step(); #1;

        chk("no_overflow", ovf_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
